// File: rtl/pc_bpred.sv
// pc_bpred -- fetch program counter with a small fully associative branch
// history table of saturating counters.
//
// The block drives pc_o to instruction memory, decodes the instruction that
// comes back in the same cycle, and speculatively redirects on conditional
// branches that the table (or, on a table miss, the static backward-taken
// rule) predicts taken. Execute-stage feedback on train_* updates counters;
// jump_* redirects recover from mispredictions and flush on interrupts or
// exceptions.
//
// Optional feature macro: PC_BPRED_JAL_EN
//   When defined, JAL instructions redirect unconditionally to pc_o + imm_j
//   at fetch time without using a table entry. When undefined, JAL falls
//   through to pc+4 and is resolved later by a cause-3 redirect.
//
// Parameters:
//   ADDR_W    PC / address width
//   ENTRIES   table entries, power of two, 2..16
//   CNT_W     saturating counter width, 2..4
//   RESET_PC  pc_o value after reset
//
// Ports:
//   clk                clock, rising edge
//   rst                asynchronous active-high reset
//   jump_cause_i[2:0]  0 none, 1/2 mispredict, 3 unconditional, 4 interrupt,
//                      5 exception, 6-7 behave like 3
//   jump_to_addr_i     redirect target
//   hold_i             pipeline stall, pc_o holds
//   inst_i[31:0]       instruction fetched at the current pc_o
//   train_valid_i      a conditional branch resolved in execute
//   train_addr_i       PC of the resolved branch
//   train_taken_i      actual outcome of the resolved branch
//   pc_o               registered fetch PC
//   predict_to_jump_o  combinational: current inst_i is redirected at fetch
//   predict_hit_o      combinational: current pc_o hits a valid table entry

module pc_bpred #(
  parameter int                 ADDR_W   = 32,
  parameter int                 ENTRIES  = 4,
  parameter int                 CNT_W    = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        jump_cause_i,
  input  logic [ADDR_W-1:0] jump_to_addr_i,
  input  logic              hold_i,
  input  logic [31:0]       inst_i,
  input  logic              train_valid_i,
  input  logic [ADDR_W-1:0] train_addr_i,
  input  logic              train_taken_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              predict_to_jump_o,
  output logic              predict_hit_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] TAKEN_MIN = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Table state
  logic [ENTRIES-1:0] valid_q;
  logic [ADDR_W-1:0]  tag_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q [ENTRIES];
  logic [IDX_W-1:0]   rr_q;
  logic [ADDR_W-1:0]  pc_q;

  // Instruction decode
  logic              is_b;
  logic [12:0]       imm_b13;
  logic [ADDR_W-1:0] imm_b;
  logic              jal_taken;
  logic [ADDR_W-1:0] jal_off;

  assign is_b    = (inst_i[6:0] == 7'b1100011);
  assign imm_b13 = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_b   = ADDR_W'($signed(imm_b13));

  // Redirect classification
  logic redirect;
  logic flush;
  logic fetch_ok;

  assign redirect = (jump_cause_i != 3'd0);
  assign flush    = (jump_cause_i == 3'd4) || (jump_cause_i == 3'd5);
  // Prediction only acts when neither a redirect nor a stall overrides it.
  assign fetch_ok = !redirect && !hold_i;

`ifdef PC_BPRED_JAL_EN
  logic        is_jal;
  logic [20:0] imm_j21;

  assign is_jal    = (inst_i[6:0] == 7'b1101111);
  assign imm_j21   = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign jal_off   = ADDR_W'($signed(imm_j21));
  assign jal_taken = fetch_ok && is_jal;
`else
  // rs1/funct3/rs2 fields carry nothing for fetch when JAL is not decoded.
  logic unused_inst_bits;

  assign unused_inst_bits = ^inst_i[24:12];
  assign jal_off          = '0;
  assign jal_taken        = 1'b0;
`endif

  // Fetch-side lookup against pc_o
  logic             f_hit;
  logic [IDX_W-1:0] f_idx;

  always_comb begin
    f_hit = 1'b0;
    f_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == pc_q)) begin
        f_hit = 1'b1;
        f_idx = IDX_W'(i);
      end
    end
  end

  // Training-side lookup against train_addr_i
  logic             t_hit;
  logic [IDX_W-1:0] t_idx;

  always_comb begin
    t_hit = 1'b0;
    t_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == train_addr_i)) begin
        t_hit = 1'b1;
        t_idx = IDX_W'(i);
      end
    end
  end

  // Victim choice: lowest-index invalid entry, else the round-robin pointer.
  // Scanning downward leaves the lowest invalid index in inv_idx.
  logic             inv_found;
  logic [IDX_W-1:0] inv_idx;
  logic [IDX_W-1:0] victim;

  always_comb begin
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(i);
      end
    end
  end

  assign victim = inv_found ? inv_idx : rr_q;

  // Prediction and next-PC selection
  logic              b_taken;
  logic              alloc;
  logic              predict;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] next_pc;

  always_comb begin
    b_taken = 1'b0;
    if (is_b) begin
      if (f_hit) b_taken = (cnt_q[f_idx] >= TAKEN_MIN);
      else       b_taken = imm_b[ADDR_W-1];  // static: backward taken
    end
  end

  assign alloc   = fetch_ok && is_b && !f_hit;
  assign predict = fetch_ok && (b_taken || jal_taken);
  assign target  = pc_q + (jal_taken ? jal_off : imm_b);

  always_comb begin
    next_pc = pc_q + ADDR_W'(4);
    if (redirect)     next_pc = jump_to_addr_i;
    else if (hold_i)  next_pc = pc_q;
    else if (predict) next_pc = target;
  end

  // Counter training (registered only; no combinational path to outputs)
  logic             train_en;
  logic [CNT_W-1:0] t_cnt;
  logic [CNT_W-1:0] t_cnt_next;

  assign train_en = train_valid_i && t_hit && !flush;
  assign t_cnt    = cnt_q[t_idx];

  always_comb begin
    t_cnt_next = t_cnt;
    if (train_taken_i) begin
      if (t_cnt != CNT_MAX) t_cnt_next = t_cnt + CNT_W'(1);
    end else begin
      if (t_cnt != '0) t_cnt_next = t_cnt - CNT_W'(1);
    end
  end

  logic [CNT_W-1:0] alloc_cnt;
  assign alloc_cnt = imm_b[ADDR_W-1] ? TAKEN_MIN : (TAKEN_MIN - CNT_W'(1));

  // State update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= '0;
      rr_q    <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      pc_q <= next_pc;
      if (flush) begin
        // Interrupt/exception: drop the whole table; any same-cycle
        // training is discarded (alloc cannot fire while redirecting).
        valid_q <= '0;
        rr_q    <= '0;
      end else begin
        for (int i = 0; i < ENTRIES; i++) begin
          // Allocation takes precedence over training of the same entry.
          if (alloc && (victim == IDX_W'(i))) begin
            valid_q[i] <= 1'b1;
            tag_q[i]   <= pc_q;
            cnt_q[i]   <= alloc_cnt;
          end else if (train_en && (t_idx == IDX_W'(i))) begin
            cnt_q[i] <= t_cnt_next;
          end
        end
        if (alloc && !inv_found) begin
          rr_q <= (rr_q == IDX_W'(ENTRIES - 1)) ? '0 : rr_q + IDX_W'(1);
        end
      end
    end
  end

  assign pc_o              = pc_q;
  assign predict_to_jump_o = predict;
  assign predict_hit_o     = f_hit;

endmodule

// File: tb/tb_pc_bpred.sv
module tb_pc_bpred;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [2:0]  jump_cause;
  logic [31:0] jump_to_addr;
  logic        hold;
  logic [31:0] inst;
  logic        train_valid;
  logic [31:0] train_addr;
  logic        train_taken;
  logic [31:0] pc;
  logic        pred;
  logic        hit;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] e;
  logic        exp_jal_pred;
  logic [31:0] exp_jal_pc;

  logic [31:0] b_back;
  logic [31:0] b_fwd;
  logic [31:0] jal20;

  pc_bpred #(
    .ADDR_W   (32),
    .ENTRIES  (4),
    .CNT_W    (2),
    .RESET_PC (32'h100)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .jump_cause_i      (jump_cause),
    .jump_to_addr_i    (jump_to_addr),
    .hold_i            (hold),
    .inst_i            (inst),
    .train_valid_i     (train_valid),
    .train_addr_i      (train_addr),
    .train_taken_i     (train_taken),
    .pc_o              (pc),
    .predict_to_jump_o (pred),
    .predict_hit_o     (hit)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Encoders
  function automatic logic [31:0] make_b(input logic [12:0] imm);
    make_b = {imm[12], imm[10:5], 5'd0, 5'd0, 3'd0, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] make_jal(input logic [20:0] imm);
    make_jal = {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
  endfunction

  // Driver tasks
  task automatic set_in(input logic [31:0] i, input logic [2:0] c,
                        input logic [31:0] ja, input logic h,
                        input logic tv, input logic [31:0] ta, input logic tt);
    inst         = i;
    jump_cause   = c;
    jump_to_addr = ja;
    hold         = h;
    train_valid  = tv;
    train_addr   = ta;
    train_taken  = tt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] a);
    set_in(NOP, 3'd3, a, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
  endtask

  // Tests
  task automatic test_reset();
    set_in(NOP, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL rst_pc: pc_o=%h expected %h", pc, 32'h100); end
    n_cmp++; if (pred !== 1'b0) begin n_err++; $display("FAIL rst_pred: got %b expected 0", pred); end
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL rst_hit: got %b expected 0", hit); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      exp_q.push_back(32'h100 + 32'(4 * k));
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (pc !== e) begin n_err++; $display("FAIL seq_pc: pc_o=%h expected %h", pc, e); end
      n_cmp++; if (pred !== 1'b0) begin n_err++; $display("FAIL seq_pred: got %b expected 0", pred); end
    end
  endtask

  task automatic test_static_alloc();
    redirect(32'h200);
    set_in(b_back, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (pred !== 1'b1) begin n_err++; $display("FAIL back_pred: got %b expected 1", pred); end
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL back_hit: got %b expected 0", hit); end
    exp_q.push_back(32'h1F8);
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (pc !== e) begin n_err++; $display("FAIL back_pc: pc_o=%h expected %h", pc, e); end

    redirect(32'h300);
    set_in(b_fwd, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (pred !== 1'b0) begin n_err++; $display("FAIL fwd_pred: got %b expected 0", pred); end
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL fwd_hit: got %b expected 0", hit); end
    exp_q.push_back(32'h304);
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (pc !== e) begin n_err++; $display("FAIL fwd_pc: pc_o=%h expected %h", pc, e); end

    // Backward entry allocated with cnt = TAKEN_MIN: predicts taken on hit.
    redirect(32'h200);
    set_in(b_back, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL back_rehit: got %b expected 1", hit); end
    n_cmp++; if (pred !== 1'b1) begin n_err++; $display("FAIL back_repred: got %b expected 1", pred); end
    exp_q.push_back(32'h1F8);
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (pc !== e) begin n_err++; $display("FAIL back_repc: pc_o=%h expected %h", pc, e); end
  endtask

  task automatic test_training();
    redirect(32'h300);
    // cnt=1: not taken; same-cycle train must not leak into prediction.
    set_in(b_fwd, 3'd0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b1);
    #1;
    n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL tr_hit: got %b expected 1", hit); end
    n_cmp++; if (pred !== 1'b0) begin n_err++; $display("FAIL tr_pred_c1: got %b expected 0", pred); end
    exp_q.push_back(32'h304);
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (pc !== e) begin n_err++; $display("FAIL tr_pc0: pc_o=%h expected %h", pc, e); end
    // two more taken trains: 2 -> 3 -> 3
    for (int k = 0; k < 2; k++) begin
      set_in(NOP, 3'd0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b1);
      exp_q.push_back(32'h308 + 32'(4 * k));
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (pc !== e) begin n_err++; $display("FAIL tr_seq_pc: pc_o=%h expected %h", pc, e); end
    end
    redirect(32'h300);
    // cnt=3 saturated: taken; train not-taken -> 2
    set_in(b_fwd, 3'd0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b0);
    #1;
    n_cmp++; if (pred !== 1'b1) begin n_err++; $display("FAIL tr_sat_pred: got %b expected 1", pred); end
    exp_q.push_back(32'h310);
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (pc !== e) begin n_err++; $display("FAIL tr_sat_pc: pc_o=%h expected %h", pc, e); end
    // training alongside a cause-3 redirect: 2 -> 1
    set_in(NOP, 3'd3, 32'h300, 1'b0, 1'b1, 32'h300, 1'b0);
    tick();
    // cnt=1: not taken; train not-taken -> 0
    set_in(b_fwd, 3'd0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b0);
    #1;
    n_cmp++; if (pred !== 1'b0) begin n_err++; $display("FAIL tr_c1_pred: got %b expected 0", pred); end
    exp_q.push_back(32'h304);
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (pc !== e) begin n_err++; $display("FAIL tr_c1_pc: pc_o=%h expected %h", pc, e); end
    // hold with a not-taken train: floor stays 0
    set_in(NOP, 3'd0, 32'h0, 1'b1, 1'b1, 32'h300, 1'b0);
    exp_q.push_back(32'h304);
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (pc !== e) begin n_err++; $display("FAIL hold_pc: pc_o=%h expected %h", pc, e); end
    // one taken train with redirect: 0 -> 1
    set_in(NOP, 3'd3, 32'h300, 1'b0, 1'b1, 32'h300, 1'b1);
    tick();
    set_in(b_fwd, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (pred !== 1'b0) begin n_err++; $display("FAIL tr_floor_pred: got %b expected 0", pred); end
    exp_q.push_back(32'h304);
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (pc !== e) begin n_err++; $display("FAIL tr_floor_pc: pc_o=%h expected %h", pc, e); end
  endtask

  task automatic test_replacement();
    logic [31:0] a [5];
    a[0] = 32'h600; a[1] = 32'h640; a[2] = 32'h680; a[3] = 32'h6C0; a[4] = 32'hA00;
    // exception: flush table, rr=0
    set_in(NOP, 3'd5, 32'h600, 1'b0, 1'b0, 32'h0, 1'b0);
    exp_q.push_back(32'h600);
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (pc !== e) begin n_err++; $display("FAIL exc_pc: pc_o=%h expected %h", pc, e); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) redirect(a[k]);
      set_in(b_fwd, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL fill_hit[%0d]: got %b expected 0", k, hit); end
      exp_q.push_back(a[k] + 32'h4);
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (pc !== e) begin n_err++; $display("FAIL fill_pc[%0d]: pc_o=%h expected %h", k, pc, e); end
      if (k == 3) begin
        // table full, first branch still resident
        redirect(a[0]);
        set_in(b_fwd, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL full_hit: got %b expected 1", hit); end
        tick();
      end
    end
    // fifth evicted entry 0; refetch misses and evicts entry 1 (rr=1)
    redirect(a[0]);
    set_in(b_fwd, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL evict_hit: got %b expected 0", hit); end
    tick();
    redirect(a[2]);
    set_in(b_fwd, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL keep_hit: got %b expected 1", hit); end
    tick();
    redirect(a[1]);
    set_in(b_fwd, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL rr_hit: got %b expected 0", hit); end
    tick();
  endtask

  task automatic test_priority();
    redirect(32'h700);
    set_in(b_back, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    redirect(32'h700);
    // cause 1 beats hold beats predicted-taken hit
    set_in(b_back, 3'd1, 32'h400, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (pred !== 1'b0) begin n_err++; $display("FAIL pri_pred: got %b expected 0", pred); end
    n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL pri_hit: got %b expected 1", hit); end
    exp_q.push_back(32'h400);
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (pc !== e) begin n_err++; $display("FAIL pri_pc: pc_o=%h expected %h", pc, e); end
    redirect(32'h700);
    set_in(b_back, 3'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (pred !== 1'b0) begin n_err++; $display("FAIL hold_pred: got %b expected 0", pred); end
    exp_q.push_back(32'h700);
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (pc !== e) begin n_err++; $display("FAIL hold_br_pc: pc_o=%h expected %h", pc, e); end
    set_in(b_back, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (pred !== 1'b1) begin n_err++; $display("FAIL unhold_pred: got %b expected 1", pred); end
    exp_q.push_back(32'h6F8);
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (pc !== e) begin n_err++; $display("FAIL unhold_pc: pc_o=%h expected %h", pc, e); end
    // interrupt with simultaneous train
    set_in(NOP, 3'd4, 32'h700, 1'b0, 1'b1, 32'h700, 1'b1);
    exp_q.push_back(32'h700);
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (pc !== e) begin n_err++; $display("FAIL irq_pc: pc_o=%h expected %h", pc, e); end
    set_in(b_back, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL irq_hit: got %b expected 0", hit); end
    n_cmp++; if (pred !== 1'b1) begin n_err++; $display("FAIL irq_pred: got %b expected 1", pred); end
    tick();
    redirect(32'hA00);
    set_in(b_fwd, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL irq_hit2: got %b expected 0", hit); end
    tick();
  endtask

  task automatic test_collision();
    // entries: 0=0x700 (cnt 2), 1=0xA00; fill 2 and 3, rr stays 0
    redirect(32'h800);
    set_in(b_fwd, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    redirect(32'h840);
    set_in(b_fwd, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    redirect(32'h8C0);
    // allocation evicts entry 0 while training its old tag
    set_in(b_fwd, 3'd0, 32'h0, 1'b0, 1'b1, 32'h700, 1'b1);
    tick();
    redirect(32'h8C0);
    set_in(b_fwd, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL col_hit: got %b expected 1", hit); end
    n_cmp++; if (pred !== 1'b0) begin n_err++; $display("FAIL col_pred: got %b expected 0", pred); end
    tick();
    redirect(32'h700);
    set_in(b_back, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL col_old_hit: got %b expected 0", hit); end
    tick();
  endtask

  task automatic test_jal();
`ifdef PC_BPRED_JAL_EN
    exp_jal_pred = 1'b1;
    exp_jal_pc   = 32'h520;
`else
    exp_jal_pred = 1'b0;
    exp_jal_pc   = 32'h504;
`endif
    redirect(32'h500);
    set_in(jal20, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (pred !== exp_jal_pred) begin n_err++; $display("FAIL jal_pred: got %b expected %b", pred, exp_jal_pred); end
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL jal_hit: got %b expected 0", hit); end
    exp_q.push_back(exp_jal_pc);
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (pc !== e) begin n_err++; $display("FAIL jal_pc: pc_o=%h expected %h", pc, e); end
  endtask

  initial begin
    b_back = make_b(13'h1FF8);
    b_fwd  = make_b(13'd16);
    jal20  = make_jal(21'h20);
    rst = 1'b1;
    set_in(NOP, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #12;
    rst = 1'b0;
    test_reset();
    test_static_alloc();
    test_training();
    test_replacement();
    test_priority();
    test_collision();
    test_jal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
